icap_stream_arbiter: RTL and testbench
======================================

Name: icap_stream_arbiter

Overview:
- Shares the single 32-bit ICAP configuration stream between NREQ independent AXI-Stream bitstream sources, e.g. a PS DMA channel and a fabric-side bitstream cache.
- Grants whole packets (TVALID through TLAST) using round-robin priority and forwards the granted source to the ICAP stream controller's slave port.
- Reports per-packet completion and beat counts, and aborts a grant whose source stalls too long.

Parameters:
- NREQ, 2, number of requester streams (2..8)
- TIMEOUT_CYCLES, 1024, consecutive mid-packet idle cycles before abort; 0 disables the watchdog
- CNT_W, 24, width of the beat counter

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  asynchronous active-low reset
- S_AXIS_TDATA  in  32*NREQ  requester data; requester i occupies bits [32i+31:32i]
- S_AXIS_TVALID  in  NREQ  requester valid
- S_AXIS_TLAST  in  NREQ  requester end of bitstream
- S_AXIS_TREADY  out  NREQ  requester ready
- M_AXIS_TDATA  out  32  data to the ICAP stream controller
- M_AXIS_TVALID  out  1  valid to the ICAP stream controller
- M_AXIS_TLAST  out  1  last to the ICAP stream controller
- M_AXIS_TREADY  in  1  ready from the ICAP stream controller
- GRANT  out  NREQ  one-hot current owner
- BUSY  out  1  a grant is active
- DONE  out  1  one-cycle pulse when a packet completes
- DONE_ID  out  3  index of the requester that completed or timed out
- BEAT_COUNT  out  CNT_W  beats transferred in the last finished packet
- TIMEOUT  out  1  one-cycle pulse when a grant is aborted

Behaviour:
- Reset (ARESETN low, asynchronous):
  - State is IDLE; GRANT=0; BUSY=0; DONE=0; TIMEOUT=0; DONE_ID=0; BEAT_COUNT=0.
  - Round-robin pointer is NREQ-1, so requester 0 has first priority.
  - All S_AXIS_TREADY=0; M_AXIS_TVALID=0.
- State IDLE:
  - When any S_AXIS_TVALID[i]=1, pick the first requesting index searching pointer+1, pointer+2, ... modulo NREQ.
  - Register GRANT[i]=1, pointer=i, BUSY=1; go to STREAM.
  - Arbitration costs exactly one cycle. No data moves in IDLE.
- State STREAM (combinational forwarding, zero latency):
  - M_AXIS_TDATA/TVALID/TLAST come from granted index g.
  - S_AXIS_TREADY[g]=M_AXIS_TREADY; all other TREADY bits are 0.
  - Beat = M_AXIS_TVALID & M_AXIS_TREADY; the internal counter increments per beat and saturates at all-ones.
  - A beat with TLAST=1 ends the packet. On the next cycle: DONE=1, DONE_ID=g, BEAT_COUNT=count including the last beat, internal counter cleared, GRANT=0, BUSY=0, state IDLE.
- Back-to-back: the minimum gap between packets is one idle cycle. The requester that just finished has lowest priority in the next arbitration.
- Watchdog:
  - In STREAM, the idle counter increments each cycle with S_AXIS_TVALID[g]=0 and clears on any cycle with TVALID=1.
  - Backpressure (TVALID=1, TREADY=0) does not count.
  - When the idle counter reaches TIMEOUT_CYCLES: TIMEOUT pulses for one cycle with DONE_ID=g, BEAT_COUNT=beats so far, and state returns to IDLE. DONE does not pulse.
  - No TLAST is fabricated. Downstream sees a truncated stream; software recovers with an ICAP abort sequence.
- Simultaneous TLAST beat and timeout threshold: completion wins, so DONE pulses and TIMEOUT does not.
- Requester deasserting TVALID mid-packet without TLAST: the grant is held until TLAST or timeout.
- Data is passed unmodified. Bit-swapping remains in the ICAP stream controller.
- Reset mid-packet: all state clears immediately and the partial packet is discarded; no DONE or TIMEOUT is emitted.
- M_AXIS_TVALID is 0 outside STREAM. AXI-Stream rule: TVALID never depends on TREADY.

Decomposition:
- Package icap_arb_pkg:
  - state encoding (IDLE=0, STREAM=1)
  - function clog2
  - function rr_pick(req, ptr, NREQ) returning the index and a found flag
- Sub-module rr_arbiter (combinational pick plus registered pointer), reusable by other ReconROS shared resources.
- Stream mux, counters and FSM live in the top.

Test Plan:
1. Single requester 0 sends 5 beats (0xAA995566, ..., TLAST on beat 5), M_AXIS_TREADY=1 -> GRANT=01 one cycle after TVALID; M_AXIS_TDATA matches in order; DONE pulse with DONE_ID=0 and BEAT_COUNT=5; S_AXIS_TREADY[1]=0 throughout.
2. Both requesters valid at the same cycle after reset -> requester 0 is granted first; after its TLAST, requester 1 is granted after one idle cycle.
3. Downstream backpressure: M_AXIS_TREADY toggles 1,0,0,1 during a 4-beat packet -> no beat lost or duplicated, BEAT_COUNT=4, no TIMEOUT even with TIMEOUT_CYCLES=2.
4. TIMEOUT_CYCLES=8: requester 1 sends 3 beats then drops TVALID -> TIMEOUT pulse exactly 8 cycles after the last valid cycle, DONE_ID=1, BEAT_COUNT=3, DONE=0; a pending requester 0 is granted next.
5. ARESETN asserted mid-packet after beat 2 -> outputs clear within the same cycle; after release, requester 0 has first priority and a fresh packet reports the correct BEAT_COUNT.
6. TLAST beat lands on the same cycle the idle counter would hit its threshold -> DONE=1, TIMEOUT=0.

Source files
------------

// File: rtl/icap_arb_pkg.sv
// Shared types and helpers for the ICAP stream arbiter and its round-robin picker.
package icap_arb_pkg;

  // Largest supported requester count and the width of a requester index.
  localparam int MAX_REQ = 8;
  localparam int ID_W    = 3;
  localparam int CAND_W  = ID_W + 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic            found;
    logic [ID_W-1:0] idx;
  } rr_pick_t;

  // Ceiling log2, used to size counters from parameters.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // Search ptr+1, ptr+2, ... (mod nreq) and return the first active request.
  // The candidate never exceeds 2*nreq-1, so one conditional subtraction
  // replaces a modulo.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                       input logic [ID_W-1:0]    ptr,
                                       input int                 nreq);
    rr_pick_t          pick;
    logic [CAND_W-1:0] cand;
    pick = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      cand = {1'b0, ptr} + CAND_W'(k);
      if (cand >= CAND_W'(nreq)) begin
        cand = cand - CAND_W'(nreq);
      end
      if ((k <= nreq) && !pick.found && req[cand[ID_W-1:0]]) begin
        pick.found = 1'b1;
        pick.idx   = cand[ID_W-1:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: combinational choice from the request vector plus a
// registered pointer that remembers the last winner (lowest priority next).
module rr_arbiter
  import icap_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            advance,
  output logic            pick_found,
  output logic [ID_W-1:0] pick_idx
);

  logic [ID_W-1:0]    ptr_q;
  logic [ID_W-1:0]    ptr_d;
  logic [MAX_REQ-1:0] req_ext;
  rr_pick_t           pick;

  // Widen the request vector and evaluate the round-robin search.
  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    pick           = rr_pick(req_ext, ptr_q, N);
  end

  assign pick_found = pick.found;
  assign pick_idx   = pick.idx;

  // The pointer moves to the winner only when the grant is actually taken.
  always_comb begin
    ptr_d = ptr_q;
    if (advance && pick.found) begin
      ptr_d = pick.idx;
    end
  end

  // Pointer starts at N-1 so that requester 0 is searched first after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= ID_W'(N - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/icap_stream_arbiter.sv
// Packet-granular round-robin arbiter sharing one 32-bit ICAP stream between
// NREQ AXI-Stream bitstream sources, with completion reporting and a
// mid-packet stall watchdog.
module icap_stream_arbiter
  import icap_arb_pkg::*;
#(
  parameter int NREQ           = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 24
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic [32*NREQ-1:0]  S_AXIS_TDATA,
  input  logic [NREQ-1:0]     S_AXIS_TVALID,
  input  logic [NREQ-1:0]     S_AXIS_TLAST,
  output logic [NREQ-1:0]     S_AXIS_TREADY,
  output logic [31:0]         M_AXIS_TDATA,
  output logic                M_AXIS_TVALID,
  output logic                M_AXIS_TLAST,
  input  logic                M_AXIS_TREADY,
  output logic [NREQ-1:0]     GRANT,
  output logic                BUSY,
  output logic                DONE,
  output logic [2:0]          DONE_ID,
  output logic [CNT_W-1:0]    BEAT_COUNT,
  output logic                TIMEOUT
);

  localparam bit WDOG_EN = (TIMEOUT_CYCLES > 0);
  localparam int IDLE_W  = WDOG_EN ? clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES);

  arb_state_e        state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   gidx_q, gidx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic [ID_W-1:0]   done_id_q, done_id_d;
  logic [CNT_W-1:0]  beat_count_q, beat_count_d;

  logic              pick_found;
  logic [ID_W-1:0]   pick_idx;
  logic              arb_advance;
  logic [NREQ-1:0]   pick_onehot;
  logic [31:0]       data_masked [NREQ];
  logic [31:0]       sel_data;
  logic              sel_valid;
  logic              sel_last;
  logic              beat;
  logic [CNT_W-1:0]  cnt_inc;
  logic [IDLE_W-1:0] idle_inc;

  rr_arbiter #(
    .N (NREQ)
  ) u_rr (
    .clk        (ACLK),
    .rst_n      (ARESETN),
    .req        (S_AXIS_TVALID),
    .advance    (arb_advance),
    .pick_found (pick_found),
    .pick_idx   (pick_idx)
  );

  // Per-requester gating: data masked by its grant bit, ready only to the owner.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_lane
      assign data_masked[gi]   = S_AXIS_TDATA[32*gi +: 32] & {32{grant_q[gi]}};
      assign S_AXIS_TREADY[gi] = grant_q[gi] & M_AXIS_TREADY;
      assign pick_onehot[gi]   = (pick_idx == ID_W'(gi));
    end
  endgenerate

  // Zero-latency forwarding of the granted source; grant is all-zero outside
  // STREAM so the master side is quiet there without extra state decoding.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      sel_data  = sel_data | data_masked[i];
      sel_valid = sel_valid | (grant_q[i] & S_AXIS_TVALID[i]);
      sel_last  = sel_last | (grant_q[i] & S_AXIS_TLAST[i]);
    end
  end

  assign M_AXIS_TDATA  = sel_data;
  assign M_AXIS_TVALID = sel_valid;
  assign M_AXIS_TLAST  = sel_last;
  assign beat          = sel_valid & M_AXIS_TREADY;
  assign cnt_inc       = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign idle_inc      = idle_q + 1'b1;

  // Next-state logic: one-cycle arbitration in IDLE, packet tracking and
  // watchdog in STREAM. A completing TLAST beat always has TVALID high, so it
  // takes precedence over the watchdog by construction.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    gidx_d       = gidx_q;
    cnt_d        = cnt_q;
    idle_d       = idle_q;
    done_d       = 1'b0;
    timeout_d    = 1'b0;
    done_id_d    = done_id_q;
    beat_count_d = beat_count_q;
    arb_advance  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        idle_d = '0;
        if (pick_found) begin
          arb_advance = 1'b1;
          grant_d     = pick_onehot;
          gidx_d      = pick_idx;
          state_d     = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (beat) begin
          cnt_d = cnt_inc;
        end
        if (beat && sel_last) begin
          done_d       = 1'b1;
          done_id_d    = gidx_q;
          beat_count_d = cnt_inc;
          cnt_d        = '0;
          idle_d       = '0;
          grant_d      = '0;
          state_d      = ST_IDLE;
        end else if (sel_valid) begin
          // Backpressured or moving, the source is alive.
          idle_d = '0;
        end else if (WDOG_EN) begin
          if (idle_inc == IDLE_LIMIT) begin
            timeout_d    = 1'b1;
            done_id_d    = gidx_q;
            beat_count_d = cnt_q;
            cnt_d        = '0;
            idle_d       = '0;
            grant_d      = '0;
            state_d      = ST_IDLE;
          end else begin
            idle_d = idle_inc;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State and status registers; reset discards any partial packet silently.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      gidx_q       <= '0;
      cnt_q        <= '0;
      idle_q       <= '0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      done_id_q    <= '0;
      beat_count_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      gidx_q       <= gidx_d;
      cnt_q        <= cnt_d;
      idle_q       <= idle_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      done_id_q    <= done_id_d;
      beat_count_q <= beat_count_d;
    end
  end

  assign GRANT      = grant_q;
  assign BUSY       = (state_q == ST_STREAM);
  assign DONE       = done_q;
  assign TIMEOUT    = timeout_q;
  assign DONE_ID    = done_id_q;
  assign BEAT_COUNT = beat_count_q;

endmodule

// File: tb/tb_icap_stream_arbiter.sv
// Bench for icap_stream_arbiter: directed scenarios plus a randomized phase,
// all checked cycle by cycle against a behavioural model of the arbitration
// rules, and packet results checked against hand-written expectations.
module tb_icap_stream_arbiter;

  localparam int NREQ    = 3;
  localparam int TO      = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                ACLK;
  logic                ARESETN;
  logic [32*NREQ-1:0]  S_AXIS_TDATA;
  logic [NREQ-1:0]     S_AXIS_TVALID;
  logic [NREQ-1:0]     S_AXIS_TLAST;
  logic [NREQ-1:0]     S_AXIS_TREADY;
  logic [31:0]         M_AXIS_TDATA;
  logic                M_AXIS_TVALID;
  logic                M_AXIS_TLAST;
  logic                M_AXIS_TREADY;
  logic [NREQ-1:0]     GRANT;
  logic                BUSY;
  logic                DONE;
  logic [2:0]          DONE_ID;
  logic [CNT_W-1:0]    BEAT_COUNT;
  logic                TIMEOUT;

  icap_stream_arbiter #(
    .NREQ           (NREQ),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (CNT_W)
  ) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .S_AXIS_TDATA  (S_AXIS_TDATA),
    .S_AXIS_TVALID (S_AXIS_TVALID),
    .S_AXIS_TLAST  (S_AXIS_TLAST),
    .S_AXIS_TREADY (S_AXIS_TREADY),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .GRANT         (GRANT),
    .BUSY          (BUSY),
    .DONE          (DONE),
    .DONE_ID       (DONE_ID),
    .BEAT_COUNT    (BEAT_COUNT),
    .TIMEOUT       (TIMEOUT)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  // Source models: queued beats {last,data} with idle gap before each beat.
  logic [32:0] beat_q [NREQ][$];
  int          gap_q  [NREQ][$];
  logic        cur_v  [NREQ];
  logic [31:0] cur_d  [NREQ];
  logic        cur_l  [NREQ];
  int          wait_c [NREQ];
  logic        rdy_q  [$];
  bit          rand_rdy;

  // Reference model of the arbiter's visible behaviour.
  int   m_owner;
  int   m_ptr;
  int   m_cnt;
  int   m_idle;
  bit   m_done;
  bit   m_to;
  int   m_done_id;
  int   m_bc;

  // Packet results seen on the DUT: id*100 + beats, +1000 for a timeout.
  int   ev_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr = NREQ - 1;
    m_cnt = 0;
    m_idle = 0;
    m_done = 0;
    m_to = 0;
    m_done_id = 0;
    m_bc = 0;
  endtask

  task automatic sources_clear();
    for (int i = 0; i < NREQ; i++) begin
      beat_q[i].delete();
      gap_q[i].delete();
      cur_v[i] = 1'b0;
      cur_d[i] = '0;
      cur_l[i] = 1'b0;
      wait_c[i] = 0;
    end
    rdy_q.delete();
    S_AXIS_TVALID = '0;
    S_AXIS_TLAST = '0;
    S_AXIS_TDATA = '0;
  endtask

  task automatic add_beat(input int src, input logic [31:0] data, input logic last, input int gap);
    beat_q[src].push_back({last, data});
    gap_q[src].push_back(gap);
  endtask

  task automatic add_pkt(input int src, input int n, input bit with_last, input int gap);
    for (int b = 0; b < n; b++) begin
      add_beat(src, $urandom, with_last && (b == n - 1), (b == 0) ? 0 : gap);
    end
  endtask

  // One clock cycle: drive inputs, compare every output with the model, advance.
  task automatic step();
    logic [NREQ-1:0] eg;
    logic [NREQ-1:0] er;
    logic            mrdy;
    logic            ev;
    logic [31:0]     ed;
    logic            el;
    int              pick;
    bit              n_done;
    bit              n_to;
    @(negedge ACLK);
    for (int i = 0; i < NREQ; i++) begin
      if (!cur_v[i] && beat_q[i].size() > 0) begin
        if (wait_c[i] >= gap_q[i][0]) begin
          {cur_l[i], cur_d[i]} = beat_q[i].pop_front();
          void'(gap_q[i].pop_front());
          cur_v[i] = 1'b1;
          wait_c[i] = 0;
        end else begin
          wait_c[i]++;
        end
      end
      S_AXIS_TVALID[i] = cur_v[i];
      S_AXIS_TLAST[i] = cur_v[i] & cur_l[i];
      S_AXIS_TDATA[32*i +: 32] = cur_v[i] ? cur_d[i] : 32'h0;
    end
    if (m_owner >= 0 && rdy_q.size() > 0) mrdy = rdy_q.pop_front();
    else if (rand_rdy) mrdy = ($urandom_range(0, 3) != 0);
    else mrdy = 1'b1;
    M_AXIS_TREADY = mrdy;
    #1;
    eg = '0;
    er = '0;
    ev = 1'b0;
    ed = '0;
    el = 1'b0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      er[m_owner] = mrdy;
      ev = cur_v[m_owner];
      ed = cur_d[m_owner];
      el = cur_l[m_owner];
    end
    chk("grant", 32'(GRANT), 32'(eg));
    chk("busy", 32'(BUSY), 32'(m_owner >= 0));
    chk("done", 32'(DONE), 32'(m_done));
    chk("timeout", 32'(TIMEOUT), 32'(m_to));
    chk("done_id", 32'(DONE_ID), 32'(m_done_id));
    chk("beat_count", 32'(BEAT_COUNT), 32'(m_bc));
    chk("m_tvalid", 32'(M_AXIS_TVALID), 32'(ev));
    chk("s_tready", 32'(S_AXIS_TREADY), 32'(er));
    if (ev) begin
      chk("m_tdata", M_AXIS_TDATA, ed);
      chk("m_tlast", 32'(M_AXIS_TLAST), 32'(el));
    end
    if (DONE === 1'b1) ev_q.push_back(int'(DONE_ID) * 100 + int'(BEAT_COUNT));
    if (TIMEOUT === 1'b1) ev_q.push_back(1000 + int'(DONE_ID) * 100 + int'(BEAT_COUNT));

    n_done = 0;
    n_to = 0;
    if (m_owner < 0) begin
      pick = -1;
      for (int k = 1; k <= NREQ; k++) begin
        if (pick < 0 && cur_v[(m_ptr + k) % NREQ]) pick = (m_ptr + k) % NREQ;
      end
      if (pick >= 0) begin
        m_owner = pick;
        m_ptr = pick;
      end
      m_cnt = 0;
      m_idle = 0;
    end else begin
      int o;
      o = m_owner;
      if (cur_v[o] && mrdy) begin
        m_cnt = (m_cnt == CNT_MAX) ? m_cnt : m_cnt + 1;
        cur_v[o] = 1'b0;
        if (cur_l[o]) begin
          n_done = 1;
          m_done_id = o;
          m_bc = m_cnt;
          m_cnt = 0;
          m_idle = 0;
          m_owner = -1;
        end
      end
      if (!n_done) begin
        if (S_AXIS_TVALID[o]) begin
          m_idle = 0;
        end else begin
          m_idle++;
          if (m_idle == TO) begin
            n_to = 1;
            m_done_id = o;
            m_bc = m_cnt;
            m_cnt = 0;
            m_idle = 0;
            m_owner = -1;
          end
        end
      end
    end
    m_done = n_done;
    m_to = n_to;
    if (n_done) $display("[%0t] packet done    src=%0d beats=%0d", $time, m_done_id, m_bc);
    if (n_to)   $display("[%0t] packet timeout src=%0d beats=%0d", $time, m_done_id, m_bc);
  endtask

  function automatic bit all_idle();
    bit r;
    r = (m_owner < 0) && !m_done && !m_to;
    for (int i = 0; i < NREQ; i++) begin
      if (cur_v[i] || beat_q[i].size() > 0) r = 0;
    end
    return r;
  endfunction

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (!all_idle() && n < budget) begin
      step();
      n++;
    end
    step();
    step();
    chk(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic ev_chk(input string tag, input int k, input int exp);
    chk(tag, (k < ev_q.size()) ? 32'(ev_q[k]) : 32'hFFFF_FFFF, 32'(exp));
  endtask

  task automatic plain_reset();
    @(negedge ACLK);
    sources_clear();
    ARESETN = 1'b0;
    model_reset();
    @(negedge ACLK);
    ARESETN = 1'b1;
  endtask

  initial begin
    int n;
    rand_rdy = 0;
    M_AXIS_TREADY = 1'b1;
    ARESETN = 1'b0;
    sources_clear();
    model_reset();
    #2;
    chk("rst_grant", 32'(GRANT), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_mvalid", 32'(M_AXIS_TVALID), 32'd0);
    chk("rst_sready", 32'(S_AXIS_TREADY), 32'd0);
    chk("rst_count", 32'(BEAT_COUNT), 32'd0);
    chk("rst_done_id", 32'(DONE_ID), 32'd0);
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;

    // Single requester 0, five beats.
    ev_q.delete();
    add_beat(0, 32'hAA995566, 1'b0, 0);
    add_beat(0, 32'h20000000, 1'b0, 0);
    add_beat(0, 32'h30008001, 1'b0, 0);
    add_beat(0, 32'h0000000D, 1'b0, 0);
    add_beat(0, 32'h20000000, 1'b1, 0);
    drain("t1_drain", 50);
    chk("t1_nev", 32'(ev_q.size()), 32'd1);
    ev_chk("t1_ev0", 0, 5);

    // Both requesters valid on the same cycle after reset.
    plain_reset();
    ev_q.delete();
    add_pkt(0, 3, 1, 0);
    add_pkt(1, 2, 1, 0);
    drain("t2_drain", 50);
    chk("t2_nev", 32'(ev_q.size()), 32'd2);
    ev_chk("t2_ev0", 0, 3);
    ev_chk("t2_ev1", 1, 102);

    // Downstream backpressure, including a stall longer than the watchdog.
    ev_q.delete();
    add_pkt(0, 4, 1, 0);
    rdy_q = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    drain("t3_drain", 60);
    chk("t3_nev", 32'(ev_q.size()), 32'd1);
    ev_chk("t3_ev0", 0, 4);

    // Requester 1 stalls forever after 3 beats; requester 0 waits behind it.
    ev_q.delete();
    add_pkt(1, 3, 0, 0);
    add_beat(0, $urandom, 1'b0, 4);
    add_beat(0, $urandom, 1'b1, 0);
    drain("t4_drain", 60);
    chk("t4_nev", 32'(ev_q.size()), 32'd2);
    ev_chk("t4_ev0", 0, 1103);
    ev_chk("t4_ev1", 1, 2);

    // TLAST beat arrives right as the idle count sits one below the limit.
    ev_q.delete();
    add_beat(0, $urandom, 1'b0, 0);
    add_beat(0, $urandom, 1'b0, 0);
    add_beat(0, $urandom, 1'b1, TO - 1);
    drain("t6_drain", 60);
    chk("t6_nev", 32'(ev_q.size()), 32'd1);
    ev_chk("t6_ev0", 0, 3);

    // Beat counter saturation.
    ev_q.delete();
    add_pkt(2, 20, 1, 0);
    drain("t7_drain", 80);
    ev_chk("t7_ev0", 0, 200 + CNT_MAX);

    // Reset in the middle of a packet, then fresh arbitration.
    ev_q.delete();
    add_pkt(1, 5, 1, 0);
    n = 0;
    while (!(m_owner == 1 && m_cnt == 2) && n < 30) begin
      step();
      n++;
    end
    chk("t5_reach", 32'(n < 30), 32'd1);
    @(negedge ACLK);
    #2;
    ARESETN = 1'b0;
    #1;
    chk("t5_grant", 32'(GRANT), 32'd0);
    chk("t5_busy", 32'(BUSY), 32'd0);
    chk("t5_mvalid", 32'(M_AXIS_TVALID), 32'd0);
    chk("t5_sready", 32'(S_AXIS_TREADY), 32'd0);
    chk("t5_count", 32'(BEAT_COUNT), 32'd0);
    sources_clear();
    model_reset();
    @(negedge ACLK);
    ARESETN = 1'b1;
    add_pkt(1, 2, 1, 0);
    add_pkt(0, 3, 1, 0);
    drain("t5_drain", 50);
    chk("t5_nev", 32'(ev_q.size()), 32'd2);
    ev_chk("t5_ev0", 0, 3);
    ev_chk("t5_ev1", 1, 102);

    // Randomized traffic: varied lengths, gaps (some past the watchdog),
    // missing TLASTs and random downstream readiness.
    rand_rdy = 1;
    for (int p = 0; p < 40; p++) begin
      add_pkt($urandom_range(0, NREQ - 1), $urandom_range(1, 18),
              ($urandom_range(0, 5) != 0), ($urandom_range(0, 3) == 0) ? $urandom_range(0, TO + 2) : 0);
    end
    drain("rand_drain", 20000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
